// File: rtl/freq_meter.sv
// freq_meter: counts rising edges of an asynchronous input over a fixed gate
// of GATE_CYCLES system clocks and reports the count on a valid/ready
// interface. Edge count saturates at all ones and raises a sticky overflow.
// Optional macro FREQ_METER_AUTO_EN: after each handshake the next gate starts
// immediately (continuous mode); otherwise the meter returns to idle.
module freq_meter #(
  parameter int GATE_CYCLES = 100000000,
  parameter int CNT_W       = 32
) (
  input  logic             clk100mhz,
  input  logic             rst_n,
  input  logic             sig_in,
  input  logic             start,
  output logic             busy,
  output logic [CNT_W-1:0] result,
  output logic             overflow,
  output logic             valid,
  input  logic             ready
);

  // Gate counter is sized from the gate length so any gate fits regardless
  // of the edge-count width.
  localparam int                GATE_W    = (GATE_CYCLES > 2) ? $clog2(GATE_CYCLES) : 1;
  localparam logic [GATE_W-1:0] GATE_LAST = GATE_W'(GATE_CYCLES - 1);

  typedef enum logic [1:0] {
    ST_IDLE    = 2'd0,
    ST_MEASURE = 2'd1,
    ST_HOLD    = 2'd2
  } state_t;

  state_t            r_state;
  state_t            w_state_next;
  logic              r_sync1;
  logic              r_sync2;
  logic              r_prev;
  logic              w_edge;
  logic [GATE_W-1:0] r_gate_cnt;
  logic [CNT_W-1:0]  r_edge_cnt;
  logic [CNT_W-1:0]  w_edge_cnt_next;
  logic              r_ovf;
  logic              w_ovf_next;
  logic              w_gate_last;
  logic              w_clear;
  logic [CNT_W-1:0]  r_result;
  logic              r_overflow;

  // Two-flop synchronizer followed by a previous-value flop for edge detection.
  always_ff @(posedge clk100mhz or negedge rst_n) begin
    if (!rst_n) begin
      r_sync1 <= 1'b0;
      r_sync2 <= 1'b0;
      r_prev  <= 1'b0;
    end else begin
      // NOTE: non-blocking so every flop samples its pre-edge input; blocking
      // here would collapse the chain into a single stage.
      r_sync1 <= sig_in;
      r_sync2 <= r_sync1;
      r_prev  <= r_sync2;
    end
  end

  assign w_edge      = r_sync2 & ~r_prev;
  assign w_gate_last = (r_gate_cnt == GATE_LAST);

  // Saturating next edge count and sticky overflow for the current cycle.
  always_comb begin
    w_edge_cnt_next = r_edge_cnt;
    w_ovf_next      = r_ovf;
    if (w_edge) begin
      if (&r_edge_cnt) w_ovf_next = 1'b1;
      else             w_edge_cnt_next = r_edge_cnt + 1'b1;
    end
  end

  // State register.
  always_ff @(posedge clk100mhz or negedge rst_n) begin
    if (!rst_n) r_state <= ST_IDLE;
    else        r_state <= w_state_next;
  end

  // Next-state logic, status outputs and counter-clear request.
  always_comb begin
    // NOTE: every output gets a default before the case so no path can leave
    // it unassigned and infer a latch.
    w_state_next = r_state;
    busy         = 1'b0;
    valid        = 1'b0;
    w_clear      = 1'b0;
    case (r_state)
      ST_IDLE: begin
        if (start) begin
          w_state_next = ST_MEASURE;
          w_clear      = 1'b1;
        end
      end
      ST_MEASURE: begin
        busy = 1'b1;
        if (w_gate_last) w_state_next = ST_HOLD;
      end
      ST_HOLD: begin
        valid = 1'b1;
        if (ready) begin
`ifdef FREQ_METER_AUTO_EN
          w_state_next = ST_MEASURE;
          w_clear      = 1'b1;
`else
          w_state_next = ST_IDLE;
`endif
        end
      end
      default: w_state_next = ST_IDLE;
    endcase
  end

  // Gate and edge counters; the last gate cycle's edge is folded into the result.
  always_ff @(posedge clk100mhz or negedge rst_n) begin
    if (!rst_n) begin
      r_gate_cnt <= '0;
      r_edge_cnt <= '0;
      r_ovf      <= 1'b0;
      r_result   <= '0;
      r_overflow <= 1'b0;
    end else if (w_clear) begin
      r_gate_cnt <= '0;
      r_edge_cnt <= '0;
      r_ovf      <= 1'b0;
    end else if (r_state == ST_MEASURE) begin
      r_gate_cnt <= r_gate_cnt + 1'b1;
      r_edge_cnt <= w_edge_cnt_next;
      r_ovf      <= w_ovf_next;
      if (w_gate_last) begin
        r_result   <= w_edge_cnt_next;
        r_overflow <= w_ovf_next;
      end
    end
  end

  assign result   = r_result;
  assign overflow = r_overflow;

endmodule

// File: tb/tb_freq_meter.sv
// tb_freq_meter: drives freq_meter (32-bit and 4-bit count instances sharing
// all inputs) with periodic square waves and compares each completed gate
// against an edge count computed from the recorded input history.
`timescale 1ns/1ps
module tb_freq_meter;

  localparam int G  = 100;
  localparam int W  = 32;
  localparam int W4 = 4;
  localparam int MAX4 = 15;

  logic          clk100mhz = 1'b0;
  logic          rst_n     = 1'b0;
  logic          sig_in    = 1'b0;
  logic          start     = 1'b0;
  logic          ready     = 1'b0;
  logic          busy, valid, overflow;
  logic [W-1:0]  result;
  logic          busy4, valid4, overflow4;
  logic [W4-1:0] result4;

  int checks = 0;
  int errors = 0;
  int cyc    = 0;
  bit samp [0:65535];
  int gen_period = 0;
  int gen_high   = 0;
  int gen_phase  = 0;

  always #5 clk100mhz = ~clk100mhz;

  freq_meter #(.GATE_CYCLES(G), .CNT_W(W)) dut (
    .clk100mhz(clk100mhz), .rst_n(rst_n), .sig_in(sig_in), .start(start),
    .busy(busy), .result(result), .overflow(overflow), .valid(valid), .ready(ready)
  );

  freq_meter #(.GATE_CYCLES(G), .CNT_W(W4)) dut4 (
    .clk100mhz(clk100mhz), .rst_n(rst_n), .sig_in(sig_in), .start(start),
    .busy(busy4), .result(result4), .overflow(overflow4), .valid(valid4), .ready(ready)
  );

  // Record what the input looks like at every rising clock edge (0 while in reset).
  always @(posedge clk100mhz) begin
    if (cyc < 65536) samp[cyc] = rst_n ? sig_in : 1'b0;
    cyc++;
  end

  function automatic bit s_at(int k);
    if (k < 0 || k > 65535) return 1'b0;
    return samp[k];
  endfunction

  // Rising edges of the input as they reach the counter through a two-flop
  // synchronizer, over the G clock edges following the edge that took start.
  function automatic int model_edges(int k0);
    int n = 0;
    for (int j = k0 + 1; j <= k0 + G; j++)
      if (s_at(j - 2) && !s_at(j - 3)) n++;
    return n;
  endfunction

  task automatic set_gen(int period, int high, int phase);
    gen_period = period;
    gen_high   = high;
    gen_phase  = phase;
  endtask

  task automatic cycle();
    @(negedge clk100mhz);
    if (gen_period < 2) sig_in = 1'b0;
    else begin
      gen_phase = (gen_phase + 1) % gen_period;
      sig_in    = (gen_phase < gen_high);
    end
  endtask

  task automatic reset_pulse();
    rst_n = 1'b0;
    cycle();
    cycle();
    rst_n = 1'b1;
    repeat (4) cycle();
  endtask

  // Start one gate, check busy/valid timing each cycle, then compare the result.
  task automatic measure(input int extra_start_at, output int k0, output int exp_n);
    int e4;
    bit o4;
    start = 1'b1;
    k0 = cyc;
    for (int i = 0; i < G; i++) begin
      cycle();
      start = (i == extra_start_at);
      checks++;
      if (busy !== 1'b1 || valid !== 1'b0 || busy4 !== 1'b1) begin
        errors++;
        $display("FAIL gate_busy[%0d] busy=%b valid=%b busy4=%b expected busy=1 valid=0", i, busy, valid, busy4);
      end
    end
    start = 1'b0;
    cycle();
    checks++;
    if (busy !== 1'b0 || valid !== 1'b1 || valid4 !== 1'b1) begin
      errors++;
      $display("FAIL gate_end busy=%b valid=%b valid4=%b expected busy=0 valid=1", busy, valid, valid4);
    end
    exp_n = model_edges(k0);
    e4 = (exp_n > MAX4) ? MAX4 : exp_n;
    o4 = (exp_n > MAX4);
    checks++;
    if (result !== W'(exp_n) || overflow !== 1'b0) begin
      errors++;
      $display("FAIL result32 got=%0d ovf=%b expected=%0d ovf=0", result, overflow, exp_n);
    end
    checks++;
    if (result4 !== W4'(e4) || overflow4 !== o4) begin
      errors++;
      $display("FAIL result4 got=%0d ovf=%b expected=%0d ovf=%b", result4, overflow4, e4, o4);
    end
  endtask

  // Stall for a number of cycles, then complete the handshake.
  task automatic handshake(input int stall, input int exp_n);
    for (int i = 0; i < stall; i++) begin
      cycle();
      checks++;
      if (valid !== 1'b1 || result !== W'(exp_n)) begin
        errors++;
        $display("FAIL hold_stable[%0d] valid=%b result=%0d expected valid=1 result=%0d", i, valid, result, exp_n);
      end
    end
    ready = 1'b1;
    cycle();
    ready = 1'b0;
    checks++;
    if (valid !== 1'b0 || valid4 !== 1'b0) begin
      errors++;
      $display("FAIL handshake_drop valid=%b valid4=%b expected 0", valid, valid4);
    end
`ifdef FREQ_METER_AUTO_EN
    reset_pulse();
`else
    repeat (3) cycle();
    checks++;
    if (busy !== 1'b0 || valid !== 1'b0 || result !== W'(exp_n)) begin
      errors++;
      $display("FAIL idle_after_hs busy=%b valid=%b result=%0d expected busy=0 valid=0 result=%0d", busy, valid, result, exp_n);
    end
`endif
  endtask

  task automatic test_reset();
    repeat (3) cycle();
    checks++;
    if (busy !== 0 || valid !== 0 || result !== '0 || overflow !== 0 || result4 !== '0 || overflow4 !== 0) begin
      errors++;
      $display("FAIL reset_state busy=%b valid=%b result=%0d ovf=%b expected all 0", busy, valid, result, overflow);
    end
    rst_n = 1'b1;
    repeat (4) cycle();
    checks++;
    if (busy !== 0 || valid !== 0 || result !== '0) begin
      errors++;
      $display("FAIL post_reset busy=%b valid=%b result=%0d expected all 0", busy, valid, result);
    end
  endtask

  task automatic test_basic();
    int k0, n;
    set_gen(10, 5, $urandom_range(9));
    repeat (5) cycle();
    measure(-1, k0, n);
    checks++;
    if (result !== W'(10)) begin
      errors++;
      $display("FAIL basic_count got=%0d expected=10", result);
    end
    handshake(0, 10);
  endtask

  task automatic test_hold_stall();
    int k0, n;
    set_gen(0, 0, 0);
    repeat (5) cycle();
    measure(-1, k0, n);
    checks++;
    if (result !== '0) begin
      errors++;
      $display("FAIL zero_count got=%0d expected=0", result);
    end
    handshake(20, 0);
  endtask

  task automatic test_saturate();
    int k0, n;
    set_gen(4, 2, 0);
    repeat (5) cycle();
    measure(-1, k0, n);
    checks++;
    if (result !== W'(25) || result4 !== W4'(MAX4) || overflow4 !== 1'b1) begin
      errors++;
      $display("FAIL saturate got32=%0d got4=%0d ovf4=%b expected 25 15 1", result, result4, overflow4);
    end
    handshake(2, 25);
  endtask

  task automatic test_ignore_start();
    int k0, n;
    set_gen(7, 3, 1);
    repeat (5) cycle();
    measure(40, k0, n);
    start = 1'b1;
    cycle();
    start = 1'b0;
    cycle();
    checks++;
    if (valid !== 1'b1 || busy !== 1'b0 || result !== W'(n)) begin
      errors++;
      $display("FAIL start_in_hold valid=%b busy=%b result=%0d expected valid=1 busy=0 result=%0d", valid, busy, result, n);
    end
    start = 1'b1;
    ready = 1'b1;
    cycle();
    start = 1'b0;
    ready = 1'b0;
    cycle();
    checks++;
`ifdef FREQ_METER_AUTO_EN
    if (valid !== 1'b0 || busy !== 1'b1) begin
      errors++;
      $display("FAIL start_at_hs valid=%b busy=%b expected valid=0 busy=1", valid, busy);
    end
    reset_pulse();
`else
    if (valid !== 1'b0 || busy !== 1'b0) begin
      errors++;
      $display("FAIL start_at_hs valid=%b busy=%b expected valid=0 busy=0", valid, busy);
    end
`endif
  endtask

  task automatic test_random();
    int k0, n, p;
    for (int it = 0; it < 6; it++) begin
      p = $urandom_range(13, 2);
      set_gen(p, $urandom_range(p - 1, 1), $urandom_range(p - 1));
      repeat ($urandom_range(8, 4)) cycle();
      measure(-1, k0, n);
      handshake($urandom_range(5), n);
    end
  endtask

  task automatic test_reset_mid();
    int k0, n;
    set_gen(3, 1, 0);
    repeat (5) cycle();
    measure(-1, k0, n);
    handshake(0, n);
    start = 1'b1;
    cycle();
    start = 1'b0;
    repeat (30) cycle();
    #2 rst_n = 1'b0;
    #1;
    checks++;
    if (busy !== 0 || valid !== 0 || result !== '0 || overflow !== 0 || busy4 !== 0 || result4 !== '0) begin
      errors++;
      $display("FAIL async_reset busy=%b valid=%b result=%0d ovf=%b expected all 0", busy, valid, result, overflow);
    end
    cycle();
    rst_n = 1'b1;
    repeat (5) cycle();
    checks++;
    if (busy !== 0 || valid !== 0 || result !== '0) begin
      errors++;
      $display("FAIL after_mid_reset busy=%b valid=%b result=%0d expected all 0", busy, valid, result);
    end
  endtask

`ifdef FREQ_METER_AUTO_EN
  task automatic test_auto();
    int k0, n, gate;
    bit exp_v;
    set_gen(5, 2, 0);
    repeat (5) cycle();
    ready = 1'b1;
    start = 1'b1;
    k0 = cyc;
    for (int i = 0; i < 3 * (G + 1); i++) begin
      cycle();
      start = 1'b0;
      exp_v = ((i % (G + 1)) == G);
      checks++;
      if (valid !== exp_v || busy !== !exp_v) begin
        errors++;
        $display("FAIL auto_timing[%0d] valid=%b busy=%b expected valid=%b", i, valid, busy, exp_v);
      end
      if (exp_v) begin
        gate = i / (G + 1);
        n = model_edges(k0 + gate * (G + 1));
        checks++;
        if (result !== W'(n) || result !== W'(20)) begin
          errors++;
          $display("FAIL auto_result[%0d] got=%0d expected=%0d", gate, result, n);
        end
      end
    end
    ready = 1'b0;
    reset_pulse();
  endtask
`endif

  initial begin
    test_reset();
    test_basic();
    test_hold_stall();
    test_saturate();
    test_ignore_start();
    test_random();
    test_reset_mid();
`ifdef FREQ_METER_AUTO_EN
    test_auto();
`endif
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
